// File: rtl/mat_mult_pkg.sv
// Shared definitions for the streaming matrix multiplier: FSM states,
// default parameter values and a constant-evaluable ceil(log2) helper.
package mat_mult_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_N      = 4;
  localparam int DEF_LANES  = 4;
  localparam bit DEF_SIGNED = 1'b0;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    COMPUTE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  // Returns ceil(log2(value)); clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int remain;
    result = 0;
    remain = value - 1;
    while (remain > 0) begin
      result = result + 1;
      remain = remain >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mat_mult_stream_dot_product.sv
// Combinational N-element dot product: N multipliers feeding a binary adder tree.
// Element k of each input vector sits at the MSB end for k = 0.
module dot_product
  import mat_mult_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int N      = DEF_N,
  parameter bit SIGNED = DEF_SIGNED,
  localparam int ACC_W = 2 * WIDTH + clog2(N)
) (
  input  logic [N*WIDTH-1:0] i_vecA,
  input  logic [N*WIDTH-1:0] i_vecB,
  output logic [ACC_W-1:0]   o_sum
);

  // Operands are widened to the result width first; modular arithmetic at
  // ACC_W then yields the exact signed or unsigned result, which always fits.
  function automatic logic [ACC_W-1:0] extend(input logic [WIDTH-1:0] value);
    if (SIGNED) begin
      return {{(ACC_W - WIDTH){value[WIDTH-1]}}, value};
    end
    return {{(ACC_W - WIDTH){1'b0}}, value};
  endfunction

  // Heap-ordered tree: leaves live at N..2N-1, node i sums nodes 2i and 2i+1.
  logic [ACC_W-1:0] w_node [1:2*N-1];

  for (genvar k = 0; k < N; k++) begin : g_mult
    assign w_node[N+k] = extend(i_vecA[(N-1-k)*WIDTH +: WIDTH]) *
                         extend(i_vecB[(N-1-k)*WIDTH +: WIDTH]);
  end

  for (genvar i = 1; i < N; i++) begin : g_tree
    assign w_node[i] = w_node[2*i] + w_node[2*i+1];
  end

  assign o_sum = w_node[1];

endmodule

// File: rtl/mat_mult_stream.sv
// Streaming NxN matrix multiplier: loads A then B in LANES-wide beats,
// computes one C element per cycle, then streams C out row-major.
module mat_mult_stream
  import mat_mult_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int N      = DEF_N,
  parameter int LANES  = DEF_LANES,
  parameter bit SIGNED = DEF_SIGNED,
  localparam int ACC_W = 2 * WIDTH + clog2(N)
) (
  input  logic                   w_clk,
  input  logic                   w_reset,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [LANES*WIDTH-1:0] s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [LANES*ACC_W-1:0] m_data,
  output logic                   busy,
  output logic                   done
);

  localparam int ELEMS  = N * N;
  localparam int BEATS  = ELEMS / LANES;
  localparam int BEAT_W = (clog2(BEATS) > 0) ? clog2(BEATS) : 1;
  localparam int IDX_W  = clog2(N);

  state_t r_state;
  state_t w_nextState;

  logic [BEAT_W-1:0] r_inBeat;
  logic [BEAT_W-1:0] r_outBeat;
  logic [IDX_W-1:0]  r_row;
  logic [IDX_W-1:0]  r_col;
  logic              r_done;

  logic [WIDTH-1:0] r_matA [ELEMS];
  logic [WIDTH-1:0] r_matB [ELEMS];
  logic [ACC_W-1:0] r_matC [ELEMS];

  logic [N*WIDTH-1:0] w_rowA;
  logic [N*WIDTH-1:0] w_colB;
  logic [ACC_W-1:0]   w_dot;

  logic w_inFire;
  logic w_outFire;
  logic w_lastIn;
  logic w_lastOut;
  logic w_lastCell;

  assign w_inFire   = s_valid && s_ready;
  assign w_outFire  = m_valid && m_ready;
  assign w_lastIn   = (r_inBeat == BEAT_W'(BEATS - 1));
  assign w_lastOut  = (r_outBeat == BEAT_W'(BEATS - 1));
  assign w_lastCell = (r_row == IDX_W'(N - 1)) && (r_col == IDX_W'(N - 1));

  always_ff @(posedge w_clk) begin
    if (w_reset) begin
      r_state <= LOAD_A;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    s_ready     = 1'b0;
    m_valid     = 1'b0;
    busy        = 1'b0;
    case (r_state)
      LOAD_A: begin
        s_ready = 1'b1;
        if (w_inFire && w_lastIn) w_nextState = LOAD_B;
      end
      LOAD_B: begin
        s_ready = 1'b1;
        if (w_inFire && w_lastIn) w_nextState = COMPUTE;
      end
      COMPUTE: begin
        busy = 1'b1;
        if (w_lastCell) w_nextState = DRAIN;
      end
      DRAIN: begin
        busy    = 1'b1;
        m_valid = 1'b1;
        if (w_outFire && w_lastOut) w_nextState = LOAD_A;
      end
      default: w_nextState = LOAD_A;
    endcase
  end

  // Beat counters wrap on their last handshake so the next job starts at zero.
  always_ff @(posedge w_clk) begin
    if (w_reset) begin
      r_inBeat  <= '0;
      r_outBeat <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_outFire && w_lastOut;
      if (w_inFire) begin
        r_inBeat <= w_lastIn ? '0 : r_inBeat + BEAT_W'(1);
      end
      if (r_state == COMPUTE) begin
        if (r_col == IDX_W'(N - 1)) begin
          r_col <= '0;
          r_row <= (r_row == IDX_W'(N - 1)) ? '0 : r_row + IDX_W'(1);
        end else begin
          r_col <= r_col + IDX_W'(1);
        end
      end
      if (w_outFire) begin
        r_outBeat <= w_lastOut ? '0 : r_outBeat + BEAT_W'(1);
      end
    end
  end

  // Operand and result storage; A/B are deliberately not cleared on reset.
  always_ff @(posedge w_clk) begin
    for (int e = 0; e < ELEMS; e++) begin
      if (!w_reset && w_inFire && (r_inBeat == BEAT_W'(e / LANES))) begin
        if (r_state == LOAD_A) begin
          r_matA[e] <= s_data[(LANES-1-(e%LANES))*WIDTH +: WIDTH];
        end else begin
          r_matB[e] <= s_data[(LANES-1-(e%LANES))*WIDTH +: WIDTH];
        end
      end
      if ((r_state == COMPUTE) && (r_row == IDX_W'(e / N)) && (r_col == IDX_W'(e % N))) begin
        r_matC[e] <= w_dot;
      end
    end
  end

  always_comb begin
    w_rowA = '0;
    w_colB = '0;
    for (int r = 0; r < N; r++) begin
      if (r_row == IDX_W'(r)) begin
        for (int k = 0; k < N; k++) begin
          w_rowA[(N-1-k)*WIDTH +: WIDTH] = r_matA[r*N+k];
        end
      end
    end
    for (int c = 0; c < N; c++) begin
      if (r_col == IDX_W'(c)) begin
        for (int k = 0; k < N; k++) begin
          w_colB[(N-1-k)*WIDTH +: WIDTH] = r_matB[k*N+c];
        end
      end
    end
  end

  dot_product #(
    .WIDTH  (WIDTH),
    .N      (N),
    .SIGNED (SIGNED)
  ) u_dotProduct (
    .i_vecA (w_rowA),
    .i_vecB (w_colB),
    .o_sum  (w_dot)
  );

  // Output mux is purely a function of registers, so data holds during stalls.
  always_comb begin
    m_data = '0;
    if (m_valid) begin
      for (int b = 0; b < BEATS; b++) begin
        if (r_outBeat == BEAT_W'(b)) begin
          for (int l = 0; l < LANES; l++) begin
            m_data[(LANES-1-l)*ACC_W +: ACC_W] = r_matC[b*LANES+l];
          end
        end
      end
    end
  end

  assign done = r_done;

endmodule

// File: tb/tb_mat_mult_stream.sv
// Self-checking bench: unsigned and signed instances share one stimulus stream
// and are compared against a plain-arithmetic matrix product model.
module tb_mat_mult_stream;

  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int LANES = 2;
  localparam int ACC_W = 2 * WIDTH + 2;
  localparam int ELEMS = N * N;
  localparam int BEATS = ELEMS / LANES;

  logic                   w_clk   = 1'b0;
  logic                   w_reset = 1'b1;
  logic                   sValid  = 1'b0;
  logic                   mReady  = 1'b0;
  logic [LANES*WIDTH-1:0] sData   = '0;

  logic                   sReadyU, sReadyS, mValidU, mValidS;
  logic                   busyU, busyS, doneU, doneS;
  logic [LANES*ACC_W-1:0] mDataU, mDataS;

  int checks = 0;
  int errors = 0;
  int matA [ELEMS];
  int matB [ELEMS];
  int expU [ELEMS];
  int expS [ELEMS];

  always #5 w_clk = ~w_clk;

  mat_mult_stream #(.WIDTH(WIDTH), .N(N), .LANES(LANES), .SIGNED(1'b0)) u_dutU (
    .w_clk(w_clk), .w_reset(w_reset), .s_valid(sValid), .s_ready(sReadyU), .s_data(sData),
    .m_valid(mValidU), .m_ready(mReady), .m_data(mDataU), .busy(busyU), .done(doneU)
  );

  mat_mult_stream #(.WIDTH(WIDTH), .N(N), .LANES(LANES), .SIGNED(1'b1)) u_dutS (
    .w_clk(w_clk), .w_reset(w_reset), .s_valid(sValid), .s_ready(sReadyS), .s_data(sData),
    .m_valid(mValidS), .m_ready(mReady), .m_data(mDataS), .busy(busyS), .done(doneS)
  );

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int toSigned(input int v);
    return (v > 127) ? v - 256 : v;
  endfunction

  // C = A x B, interpreted both as unsigned bytes and as two's-complement bytes.
  task automatic computeRef();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        int sumU;
        int sumS;
        sumU = 0;
        sumS = 0;
        for (int k = 0; k < N; k++) begin
          sumU += matA[i*N+k] * matB[k*N+j];
          sumS += toSigned(matA[i*N+k]) * toSigned(matB[k*N+j]);
        end
        expU[i*N+j] = sumU;
        expS[i*N+j] = sumS;
      end
    end
  endtask

  function automatic logic [LANES*WIDTH-1:0] packIn(input bit useB, input int beat);
    logic [LANES*WIDTH-1:0] v;
    v = '0;
    for (int l = 0; l < LANES; l++) begin
      v[(LANES-1-l)*WIDTH +: WIDTH] = useB ? WIDTH'(matB[beat*LANES+l]) : WIDTH'(matA[beat*LANES+l]);
    end
    return v;
  endfunction

  function automatic logic [LANES*ACC_W-1:0] packExp(input bit useS, input int beat);
    logic [LANES*ACC_W-1:0] v;
    v = '0;
    for (int l = 0; l < LANES; l++) begin
      v[(LANES-1-l)*ACC_W +: ACC_W] = useS ? ACC_W'(expS[beat*LANES+l]) : ACC_W'(expU[beat*LANES+l]);
    end
    return v;
  endfunction

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_s_ready"}, {sReadyU, sReadyS}, 2'b11);
    checkOutput({tag, "_m_valid"}, {mValidU, mValidS}, 2'b00);
    checkOutput({tag, "_m_data_u"}, mDataU, 0);
    checkOutput({tag, "_m_data_s"}, mDataS, 0);
    checkOutput({tag, "_busy"}, {busyU, busyS}, 2'b00);
  endtask

  // Streams `beats` beats of A or B; starts and ends just after a falling edge.
  task automatic applyStimulus(input bit useB, input int beats, input bit gaps, input bit holdValid);
    int idx;
    int cycles;
    idx = 0;
    cycles = 0;
    while (idx < beats && cycles < 500) begin
      sValid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      sData  = packIn(useB, idx);
      if (sValid && sReadyU) idx++;
      @(negedge w_clk);
      cycles++;
    end
    if (idx < beats) checkOutput("load_timeout", idx, beats);
    sValid = holdValid;
    if (holdValid) sData = (LANES*WIDTH)'($urandom);
  endtask

  task automatic drainAndCheck(input bit randomReady, input bit holdValid);
    int beat;
    int cycles;
    bit finished;
    beat = 0;
    cycles = 0;
    finished = 1'b0;
    while (!finished && cycles < 500) begin
      @(negedge w_clk);
      cycles++;
      if (holdValid) begin
        checkOutput("s_ready_busy", {sReadyU, sReadyS}, 2'b00);
        sData = (LANES*WIDTH)'($urandom);
      end
      if (mValidU) begin
        checkOutput("m_valid_s", mValidS, 1);
        checkOutput("busy_drain", {busyU, busyS}, 2'b11);
        checkOutput($sformatf("m_data_u_b%0d", beat), mDataU, packExp(1'b0, beat));
        checkOutput($sformatf("m_data_s_b%0d", beat), mDataS, packExp(1'b1, beat));
        mReady = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
        if (mReady) begin
          beat++;
          if (beat == BEATS) begin
            finished = 1'b1;
            sValid = 1'b0;
          end
        end
      end else begin
        mReady = randomReady ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
    if (!finished) begin
      checkOutput("drain_timeout", beat, BEATS);
    end else begin
      @(negedge w_clk);
      mReady = 1'b0;
      checkOutput("done_pulse", {doneU, doneS}, 2'b11);
      checkIdle("post_drain");
      @(negedge w_clk);
      checkOutput("done_low", {doneU, doneS}, 2'b00);
    end
  endtask

  task automatic runCase(input bit gaps, input bit randomReady);
    applyStimulus(1'b0, BEATS, gaps, 1'b0);
    applyStimulus(1'b1, BEATS, gaps, 1'b0);
    computeRef();
    drainAndCheck(randomReady, 1'b0);
  endtask

  task automatic randomMatrices();
    for (int i = 0; i < ELEMS; i++) begin
      matA[i] = $urandom_range(0, 255);
      matB[i] = $urandom_range(0, 255);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (3) @(negedge w_clk);
    w_reset = 1'b0;
    checkIdle("reset");
    checkOutput("reset_done", {doneU, doneS}, 2'b00);

    for (int i = 0; i < ELEMS; i++) begin
      matA[i] = (i / N == i % N) ? 1 : 0;
      matB[i] = i + 1;
    end
    runCase(1'b0, 1'b0);

    for (int i = 0; i < ELEMS; i++) begin
      matA[i] = 255;
      matB[i] = 255;
    end
    runCase(1'b0, 1'b0);

    for (int i = 0; i < ELEMS; i++) begin
      matA[i] = 128;
      matB[i] = 128;
    end
    runCase(1'b1, 1'b1);

    for (int i = 0; i < ELEMS; i++) begin
      matA[i] = 255;
      matB[i] = 1;
    end
    runCase(1'b1, 1'b0);

    for (int t = 0; t < 4; t++) begin
      randomMatrices();
      runCase(1'b1, 1'b1);
    end

    // Abort partway through loading B; reset must win over the concurrent beat.
    randomMatrices();
    applyStimulus(1'b0, BEATS, 1'b1, 1'b0);
    applyStimulus(1'b1, 5, 1'b1, 1'b0);
    sValid  = 1'b1;
    w_reset = 1'b1;
    @(negedge w_clk);
    w_reset = 1'b0;
    sValid  = 1'b0;
    checkIdle("mid_reset");
    checkOutput("mid_reset_done", {doneU, doneS}, 2'b00);
    randomMatrices();
    runCase(1'b1, 1'b1);

    // s_valid stays high with junk data through COMPUTE and DRAIN.
    randomMatrices();
    applyStimulus(1'b0, BEATS, 1'b0, 1'b0);
    applyStimulus(1'b1, BEATS, 1'b0, 1'b1);
    computeRef();
    drainAndCheck(1'b1, 1'b1);
    randomMatrices();
    runCase(1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
